control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Moore-style timing/control FSM for the 32-bit bus CPU.
- Sits directly upstream of the register select/encode stage. Drives Gra/Grb/Grc/Rin/Rout/BAout/Cout and all other bus, ALU and memory strobes.
- Decodes the opcode in IR[31:27] and steps each instruction through fetch (T0–T2) and execute (T3–T7) cycles.
- Supports ALU reg-reg, ALU immediate, ld, ldi, st, nop and halt.

Parameters:
- MEM_WAIT, 0, extra stall cycles held in each memory-access state (T1 fetch read, T6 ld read, T7 st write); range 0–7.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- IR  in  32  current instruction register contents
- stop  in  1  request halt at next instruction boundary
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout  out  1 each  datapath bus strobes
- Read, Write  out  1 each  memory strobes
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  to register select/encode stage
- alu_op  out  5  ALU operation code; equals the opcode, or 5'b00011 (ADD) for address/ldi computation
- run  out  1  high while executing; low in HALT and during reset

Behaviour:
- Opcodes (IR[31:27]):
  - ld 00000, ldi 00001, st 00010
  - ALU reg-reg 00011–01010 (add, sub, shr, shl, ror, rol, and, or)
  - ALU immediate 01011–01101 (addi, andi, ori)
  - nop 11001, halt 11010
  - Every other opcode executes as nop.
- States: RST, T0–T7, HALT. A 3-bit wait counter is shared by the memory states.
- Outputs are decoded from the registered state only, with no input-to-output paths except alu_op, which follows IR in T4.
- Every strobe not listed for a state is 0.
- reset high on any clock edge:
  - state <= RST, wait counter <= 0
  - in RST all outputs = 0, run = 0
  - next edge with reset low goes to T0
  - reset aborts any instruction in progress, including mid-wait.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Held for MEM_WAIT+1 cycles. PCin pulses only on the first of these cycles. Read and MDRin stay high throughout.
  - T2: MDRout, IRin.
- After T2, branch on the opcode now valid in IR:
  - nop/unknown → T0
  - halt → HALT
  - all others → T3
- ALU reg-reg:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op = opcode.
  - T5: Zlowout, Gra, Rin.
- ALU immediate: same as reg-reg except T4 uses Cout instead of Grc/Rout.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op = ADD.
  - T5: Zlowout, Gra, Rin.
- ld:
  - T3, T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin, held for MEM_WAIT+1 cycles.
  - T7: MDRout, Gra, Rin.
- st:
  - T3, T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin.
  - T7: Write, held for MEM_WAIT+1 cycles.
- Instruction end is the last execute state (T5 for ALU/ldi, T7 for ld/st). Its successor is HALT if stop was high on that edge, else T0.
- stop asserted at any other time is not latched; it must be held until an instruction boundary.
- HALT: all strobes 0, run = 0. Exit only via reset.
- Wait counter:
  - Loads MEM_WAIT on entry to a memory state.
  - Decrements each cycle; the state advances when the counter is 0.
  - With MEM_WAIT = 0 each memory state lasts exactly 1 cycle.
- Cycle counts with MEM_WAIT = 0: nop 3, ALU/ldi 6, ld/st 8.

Test Plan:
- Reset held 2 cycles, then released; IR = nop (0xC8000000) → all outputs 0 and run = 0 in RST; T0, T1, T2 strobes in order; back in T0 on the 4th post-reset edge.
- IR = add R1,R2,R3 (0x18918000), MEM_WAIT = 0 → T3 Grb&Rout&Yin, T4 Grc&Rout&Zin with alu_op = 00011, T5 Gra&Rin; 6 cycles total.
- IR = ld (0x00800064), MEM_WAIT = 2 → T1 Read held 3 cycles with PCin high only on the first; T3 BAout; T4 alu_op = 00011 with Cout; T6 Read held 3 cycles; T7 Gra&Rin.
- IR = st (0x10800010) → T6 Gra&Rout&MDRin, T7 Write for exactly 1 cycle, no Rin asserted anywhere; then T0.
- IR = halt (0xD0000000) → T2 goes to HALT; run = 0 and all strobes 0 for 20+ cycles; reset returns to RST and then T0.
- stop pulsed in T5 of an addi → next state HALT. stop pulsed only during T3 → ignored, next fetch occurs. reset asserted during a T6 wait → RST on that edge, T0 after release.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Bundle of instruction/stop inputs and the datapath, memory and register-select
// strobes exchanged between the control sequencer and the CPU datapath.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        stop;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
    logic        Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic [4:0]  alu_op;
    logic        run;

    modport master (
        input  IR, stop,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
        output Read, Write,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        output alu_op, run
    );

    modport slave (
        output IR, stop,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
        input  Read, Write,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        input  alu_op, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore timing/control FSM for the 32-bit bus CPU: fetch in T0-T2, execute in
// T3-T7, with a shared wait counter stretching every memory-access state.
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_NOP, C_HALT, C_LD, C_LDI, C_ST, C_RR, C_IMM
    } op_class_e;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);
    localparam logic [4:0] OP_ADD    = 5'b00011;

    state_e     state_q, state_d;
    op_class_e  cls_q, cls_d;
    logic [2:0] wait_q, wait_d;
    logic [4:0] opcode;

    assign opcode = bus.IR[31:27];

    function automatic op_class_e decode(input logic [4:0] op);
        op_class_e c;
        if (op == 5'b00000)                       c = C_LD;
        else if (op == 5'b00001)                  c = C_LDI;
        else if (op == 5'b00010)                  c = C_ST;
        else if (op >= 5'b00011 && op <= 5'b01010) c = C_RR;
        else if (op >= 5'b01011 && op <= 5'b01101) c = C_IMM;
        else if (op == 5'b11010)                  c = C_HALT;
        else                                      c = C_NOP;
        return c;
    endfunction

    // State register; the instruction class is captured at the T2 branch so
    // execute-phase strobes depend only on registered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RST;
            wait_q  <= 3'd0;
            cls_q   <= C_NOP;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cls_q   <= cls_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cls_d   = cls_q;
        unique case (state_q)
            S_RST: state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                wait_d  = WAIT_LOAD;
            end
            S_T1: begin
                if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
                else                state_d = S_T2;
            end
            S_T2: begin
                unique case (decode(opcode))
                    C_NOP:   state_d = S_T0;
                    C_HALT:  state_d = S_HALT;
                    default: begin
                        state_d = S_T3;
                        cls_d   = decode(opcode);
                    end
                endcase
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls_q == C_LD || cls_q == C_ST) begin
                    state_d = S_T6;
                    if (cls_q == C_LD) wait_d = WAIT_LOAD;
                end else begin
                    state_d = bus.stop ? S_HALT : S_T0;
                end
            end
            S_T6: begin
                if (cls_q == C_LD) begin
                    if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
                    else                state_d = S_T7;
                end else begin
                    state_d = S_T7;
                    wait_d  = WAIT_LOAD;
                end
            end
            S_T7: begin
                if (cls_q == C_ST && wait_q != 3'd0) wait_d = wait_q - 3'd1;
                else                                 state_d = bus.stop ? S_HALT : S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out;
    logic rd, wr, gra, grb, grc, r_in, r_out, ba_out, c_out, run;
    logic [4:0] alu_op;

    // Output decode
    always_comb begin
        pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
        mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0;
        rd = 1'b0; wr = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
        r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0; c_out = 1'b0;
        alu_op = 5'b00000;
        run = 1'b0;
        unique case (state_q)
            S_T0: begin
                run = 1'b1; pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
            end
            S_T1: begin
                run = 1'b1; zlow_out = 1'b1; rd = 1'b1; mdr_in = 1'b1;
                pc_in = (wait_q == WAIT_LOAD);
            end
            S_T2: begin
                run = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                run = 1'b1; grb = 1'b1; y_in = 1'b1;
                if (cls_q == C_RR || cls_q == C_IMM) r_out  = 1'b1;
                else                                 ba_out = 1'b1;
            end
            S_T4: begin
                run = 1'b1; z_in = 1'b1;
                unique case (cls_q)
                    C_RR:    begin grc = 1'b1; r_out = 1'b1; alu_op = opcode; end
                    C_IMM:   begin c_out = 1'b1; alu_op = opcode; end
                    default: begin c_out = 1'b1; alu_op = OP_ADD; end
                endcase
            end
            S_T5: begin
                run = 1'b1; zlow_out = 1'b1;
                if (cls_q == C_LD || cls_q == C_ST) mar_in = 1'b1;
                else begin gra = 1'b1; r_in = 1'b1; end
            end
            S_T6: begin
                run = 1'b1; mdr_in = 1'b1;
                if (cls_q == C_LD) rd = 1'b1;
                else begin gra = 1'b1; r_out = 1'b1; end
            end
            S_T7: begin
                run = 1'b1;
                if (cls_q == C_LD) begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                else wr = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCout   = pc_out;
    assign bus.PCin    = pc_in;
    assign bus.IncPC   = inc_pc;
    assign bus.MARin   = mar_in;
    assign bus.MDRin   = mdr_in;
    assign bus.MDRout  = mdr_out;
    assign bus.IRin    = ir_in;
    assign bus.Yin     = y_in;
    assign bus.Zin     = z_in;
    assign bus.Zlowout = zlow_out;
    assign bus.Read    = rd;
    assign bus.Write   = wr;
    assign bus.Gra     = gra;
    assign bus.Grb     = grb;
    assign bus.Grc     = grc;
    assign bus.Rin     = r_in;
    assign bus.Rout    = r_out;
    assign bus.BAout   = ba_out;
    assign bus.Cout    = c_out;
    assign bus.alu_op  = alu_op;
    assign bus.run     = run;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer: two instances (MEM_WAIT 0 and 2)
// share clock, reset, IR and stop; each vector checks one instance after an edge.
module tb_control_sequencer;

    logic clock;
    logic reset;

    control_sequencer_if if0 ();
    control_sequencer_if if2 ();

    control_sequencer #(.MEM_WAIT(0)) dut0 (.clock(clock), .reset(reset), .bus(if0));
    control_sequencer #(.MEM_WAIT(2)) dut2 (.clock(clock), .reset(reset), .bus(if2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view: strobes [24:6], alu_op [5:1], run [0]
    logic [24:0] act0, act2;
    assign act0 = {if0.PCout, if0.PCin, if0.IncPC, if0.MARin, if0.MDRin, if0.MDRout, if0.IRin,
                   if0.Yin, if0.Zin, if0.Zlowout, if0.Read, if0.Write, if0.Gra, if0.Grb,
                   if0.Grc, if0.Rin, if0.Rout, if0.BAout, if0.Cout, if0.alu_op, if0.run};
    assign act2 = {if2.PCout, if2.PCin, if2.IncPC, if2.MARin, if2.MDRin, if2.MDRout, if2.IRin,
                   if2.Yin, if2.Zin, if2.Zlowout, if2.Read, if2.Write, if2.Gra, if2.Grb,
                   if2.Grc, if2.Rin, if2.Rout, if2.BAout, if2.Cout, if2.alu_op, if2.run};

    localparam logic [24:0] B_PCOUT = 25'd1 << 24, B_PCIN = 25'd1 << 23, B_INCPC = 25'd1 << 22;
    localparam logic [24:0] B_MARIN = 25'd1 << 21, B_MDRIN = 25'd1 << 20, B_MDROUT = 25'd1 << 19;
    localparam logic [24:0] B_IRIN = 25'd1 << 18, B_YIN = 25'd1 << 17, B_ZIN = 25'd1 << 16;
    localparam logic [24:0] B_ZLOW = 25'd1 << 15, B_READ = 25'd1 << 14, B_WRITE = 25'd1 << 13;
    localparam logic [24:0] B_GRA = 25'd1 << 12, B_GRB = 25'd1 << 11, B_GRC = 25'd1 << 10;
    localparam logic [24:0] B_RIN = 25'd1 << 9, B_ROUT = 25'd1 << 8, B_BAOUT = 25'd1 << 7;
    localparam logic [24:0] B_COUT = 25'd1 << 6, B_RUN = 25'd1;

    localparam logic [24:0] E_RST  = 25'd0;
    localparam logic [24:0] E_HALT = 25'd0;
    localparam logic [24:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
    localparam logic [24:0] E_T1   = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [24:0] E_T1W  = B_ZLOW | B_READ | B_MDRIN | B_RUN;
    localparam logic [24:0] E_T2   = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [24:0] E_RR3  = B_GRB | B_ROUT | B_YIN | B_RUN;
    localparam logic [24:0] E_RR4  = B_GRC | B_ROUT | B_ZIN | B_RUN;
    localparam logic [24:0] E_IMM4 = B_COUT | B_ZIN | B_RUN;
    localparam logic [24:0] E_WB5  = B_ZLOW | B_GRA | B_RIN | B_RUN;
    localparam logic [24:0] E_A3   = B_GRB | B_BAOUT | B_YIN | B_RUN;
    localparam logic [24:0] E_A4   = B_COUT | B_ZIN | (25'd3 << 1) | B_RUN;
    localparam logic [24:0] E_M5   = B_ZLOW | B_MARIN | B_RUN;
    localparam logic [24:0] E_LD6  = B_READ | B_MDRIN | B_RUN;
    localparam logic [24:0] E_LD7  = B_MDROUT | B_GRA | B_RIN | B_RUN;
    localparam logic [24:0] E_ST6  = B_GRA | B_ROUT | B_MDRIN | B_RUN;
    localparam logic [24:0] E_ST7  = B_WRITE | B_RUN;

    localparam logic [31:0] I_NOP = 32'hC800_0000, I_ADD = 32'h1891_8000, I_ADDI = 32'h5800_0000;
    localparam logic [31:0] I_SUB = 32'h2000_0000, I_UNK = 32'hF800_0000, I_LDI = 32'h0880_0000;
    localparam logic [31:0] I_ST  = 32'h1080_0010, I_HLT = 32'hD000_0000, I_LD  = 32'h0080_0064;

    typedef struct {
        bit          sel;     // 0: MEM_WAIT=0 instance, 1: MEM_WAIT=2 instance
        bit          rst;
        logic [31:0] ir;
        bit          stop;
        logic [24:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [24:0] op(input int unsigned code);
        return 25'(code) << 1;
    endfunction

    function automatic void v(bit sel, bit rst, logic [31:0] ir, bit stop, logic [24:0] exp, string tag);
        vec_t r;
        r.sel = sel; r.rst = rst; r.ir = ir; r.stop = stop; r.exp = exp; r.tag = tag;
        vecs.push_back(r);
    endfunction

    task automatic drive(input bit rst, input logic [31:0] ir, input bit stop);
        reset = rst;
        if0.IR = ir;  if2.IR = ir;
        if0.stop = stop; if2.stop = stop;
    endtask

    task automatic check(input string tag, input logic [24:0] act, input logic [24:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %07h expected %07h", tag, act, exp);
        end else begin
            $display("[TB] ok   %s: %07h", tag, act);
        end
    endtask

    task automatic apply(input vec_t r);
        @(negedge clock);
        drive(r.rst, r.ir, r.stop);
        @(posedge clock);
        #1;
        check(r.tag, r.sel ? act2 : act0, r.exp);
    endtask

    int n_a;

    initial begin
        drive(1'b1, I_NOP, 1'b0);

        // MEM_WAIT=0: reset, nop fetch, add, addi+stop, sub with stale stop, unknown, ldi, st, halt
        v(0, 1, I_NOP, 0, E_RST, "rst c1");   v(0, 1, I_NOP, 0, E_RST, "rst c2");
        v(0, 0, I_NOP, 0, E_T0, "nop T0");    v(0, 0, I_NOP, 0, E_T1, "nop T1");
        v(0, 0, I_NOP, 0, E_T2, "nop T2");    v(0, 0, I_NOP, 0, E_T0, "nop back T0");
        v(0, 0, I_ADD, 0, E_T1, "add T1");    v(0, 0, I_ADD, 0, E_T2, "add T2");
        v(0, 0, I_ADD, 0, E_RR3, "add T3");   v(0, 0, I_ADD, 0, E_RR4 | op(3), "add T4");
        v(0, 0, I_ADD, 0, E_WB5, "add T5");   v(0, 0, I_ADD, 0, E_T0, "add end T0");
        v(0, 0, I_ADDI, 0, E_T1, "addi T1");  v(0, 0, I_ADDI, 0, E_T2, "addi T2");
        v(0, 0, I_ADDI, 0, E_RR3, "addi T3"); v(0, 0, I_ADDI, 0, E_IMM4 | op(11), "addi T4");
        v(0, 0, I_ADDI, 0, E_WB5, "addi T5"); v(0, 0, I_ADDI, 1, E_HALT, "addi stop HALT");
        v(0, 0, I_ADDI, 0, E_HALT, "halt hold"); v(0, 1, I_SUB, 0, E_RST, "halt reset RST");
        v(0, 0, I_SUB, 0, E_T0, "sub T0");    v(0, 0, I_SUB, 0, E_T1, "sub T1");
        v(0, 0, I_SUB, 0, E_T2, "sub T2");    v(0, 0, I_SUB, 0, E_RR3, "sub T3");
        v(0, 0, I_SUB, 1, E_RR4 | op(4), "sub T4 stop ign"); v(0, 0, I_SUB, 0, E_WB5, "sub T5");
        v(0, 0, I_SUB, 0, E_T0, "sub fetch T0");
        v(0, 0, I_UNK, 0, E_T1, "unk T1");    v(0, 0, I_UNK, 0, E_T2, "unk T2");
        v(0, 0, I_UNK, 0, E_T0, "unk T0");
        v(0, 0, I_LDI, 0, E_T1, "ldi T1");    v(0, 0, I_LDI, 0, E_T2, "ldi T2");
        v(0, 0, I_LDI, 0, E_A3, "ldi T3");    v(0, 0, I_LDI, 0, E_A4, "ldi T4");
        v(0, 0, I_LDI, 0, E_WB5, "ldi T5");   v(0, 0, I_LDI, 0, E_T0, "ldi end T0");
        v(0, 0, I_ST, 0, E_T1, "st T1");      v(0, 0, I_ST, 0, E_T2, "st T2");
        v(0, 0, I_ST, 0, E_A3, "st T3");      v(0, 0, I_ST, 0, E_A4, "st T4");
        v(0, 0, I_ST, 0, E_M5, "st T5");      v(0, 0, I_ST, 0, E_ST6, "st T6");
        v(0, 0, I_ST, 0, E_ST7, "st T7");     v(0, 0, I_ST, 0, E_T0, "st end T0");
        v(0, 0, I_HLT, 0, E_T1, "halt T1");   v(0, 0, I_HLT, 0, E_T2, "halt T2");
        v(0, 0, I_HLT, 0, E_HALT, "halt HALT");
        n_a = vecs.size();

        // MEM_WAIT=2: ld with stretched T1/T6, reset mid-T6 wait, st with stretched T7
        v(1, 1, I_LD, 0, E_RST, "w2 rst");    v(1, 0, I_LD, 0, E_T0, "ld T0");
        v(1, 0, I_LD, 0, E_T1, "ld T1 c1");   v(1, 0, I_LD, 0, E_T1W, "ld T1 c2");
        v(1, 0, I_LD, 0, E_T1W, "ld T1 c3");  v(1, 0, I_LD, 0, E_T2, "ld T2");
        v(1, 0, I_LD, 0, E_A3, "ld T3");      v(1, 0, I_LD, 0, E_A4, "ld T4");
        v(1, 0, I_LD, 0, E_M5, "ld T5");      v(1, 0, I_LD, 0, E_LD6, "ld T6 c1");
        v(1, 0, I_LD, 0, E_LD6, "ld T6 c2");  v(1, 0, I_LD, 0, E_LD6, "ld T6 c3");
        v(1, 0, I_LD, 0, E_LD7, "ld T7");     v(1, 0, I_LD, 0, E_T0, "ld end T0");
        v(1, 0, I_LD, 0, E_T1, "ld2 T1 c1");  v(1, 0, I_LD, 0, E_T1W, "ld2 T1 c2");
        v(1, 0, I_LD, 0, E_T1W, "ld2 T1 c3"); v(1, 0, I_LD, 0, E_T2, "ld2 T2");
        v(1, 0, I_LD, 0, E_A3, "ld2 T3");     v(1, 0, I_LD, 0, E_A4, "ld2 T4");
        v(1, 0, I_LD, 0, E_M5, "ld2 T5");     v(1, 0, I_LD, 0, E_LD6, "ld2 T6 c1");
        v(1, 0, I_LD, 0, E_LD6, "ld2 T6 c2"); v(1, 1, I_LD, 0, E_RST, "ld2 reset in wait");
        v(1, 0, I_LD, 0, E_T0, "post rst T0"); v(1, 0, I_ST, 0, E_T1, "st2 T1 c1");
        v(1, 0, I_ST, 0, E_T1W, "st2 T1 c2"); v(1, 0, I_ST, 0, E_T1W, "st2 T1 c3");
        v(1, 0, I_ST, 0, E_T2, "st2 T2");     v(1, 0, I_ST, 0, E_A3, "st2 T3");
        v(1, 0, I_ST, 0, E_A4, "st2 T4");     v(1, 0, I_ST, 0, E_M5, "st2 T5");
        v(1, 0, I_ST, 0, E_ST6, "st2 T6");    v(1, 0, I_ST, 0, E_ST7, "st2 T7 c1");
        v(1, 0, I_ST, 0, E_ST7, "st2 T7 c2"); v(1, 0, I_ST, 0, E_ST7, "st2 T7 c3");
        v(1, 0, I_ST, 1, E_HALT, "st2 stop HALT");

        for (int i = 0; i < n_a; i++) apply(vecs[i]);

        // HALT must ignore stop and new opcodes until reset
        for (int k = 0; k < 22; k++) begin
            @(negedge clock);
            drive(1'b0, (k % 2 == 0) ? I_ADD : I_NOP, k[0]);
            @(posedge clock);
            #1;
            check($sformatf("halt hold %0d", k), act0, E_HALT);
        end
        @(negedge clock); drive(1'b1, I_NOP, 1'b0);
        @(posedge clock); #1; check("halt exit RST", act0, E_RST);
        @(negedge clock); drive(1'b0, I_NOP, 1'b0);
        @(posedge clock); #1; check("halt exit T0", act0, E_T0);

        for (int i = n_a; i < vecs.size(); i++) apply(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
